// File: rtl/mk_sync_hs_pkg.sv
// ---------------------------------------------------------------------------
// mk_sync_hs_pkg
// Shared definitions for the destination side of the 4-phase req/ack
// clock-domain-crossing handshake:
//   - FSM state encodings and the 2-bit state enum (IDLE/VALID/ACK)
//   - minimum legal depth of the request synchroniser
// ---------------------------------------------------------------------------
package mk_sync_hs_pkg;

  localparam logic [1:0] ST_IDLE_ENC  = 2'b00;
  localparam logic [1:0] ST_VALID_ENC = 2'b01;
  localparam logic [1:0] ST_ACK_ENC   = 2'b10;

  localparam int SYNC_STAGE_MIN = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_VALID = ST_VALID_ENC,
    ST_ACK   = ST_ACK_ENC
  } hs_state_e;

endpackage

// File: rtl/mk_sync_l2l.sv
// ---------------------------------------------------------------------------
// mk_sync_l2l
// Level-to-level multi-flop synchroniser for a single asynchronous bit.
// Parameters:
//   SYNC_STAGE  - number of flops in the chain (>= SYNC_STAGE_MIN)
//   RESET_VALUE - value loaded into every flop during reset
// Ports:
//   clk    - destination clock
//   resetn - asynchronous active-low reset
//   d      - asynchronous input level
//   q      - synchronised level, SYNC_STAGE clock edges after d
// ---------------------------------------------------------------------------
module mk_sync_l2l
  import mk_sync_hs_pkg::*;
#(
  parameter int   SYNC_STAGE  = 2,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  if (SYNC_STAGE < SYNC_STAGE_MIN) begin : g_bad_depth
    $error("mk_sync_l2l: SYNC_STAGE must be at least %0d", SYNC_STAGE_MIN);
  end

  logic [SYNC_STAGE-1:0] sync_q;
  logic [SYNC_STAGE-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGE-2:0], d};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= {SYNC_STAGE{RESET_VALUE}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[SYNC_STAGE-1];

endmodule

// File: rtl/mk_sync_hs_rx.sv
// ---------------------------------------------------------------------------
// mk_sync_hs_rx
// Destination endpoint of a 4-phase req/ack CDC handshake. The request level
// is synchronised, the quasi-static data bus is captured on the synchronised
// request rise, offered locally on a valid/ready interface, and an ack level
// is returned to the source once the word has been accepted.
//
// Parameters:
//   DATA_WIDTH - transferred word width (1..1024)
//   SYNC_STAGE - request synchroniser depth (2..4)
// Ports:
//   clk        - destination clock
//   resetn     - asynchronous active-low reset
//   req_async  - request level from source domain (unsynchronised)
//   data_async - source data, stable from req rise until ack rise
//   ack        - registered acknowledge level to source domain
//   out_valid  - captured word available
//   out_ready  - local consumer accepts word
//   out_data   - captured word, stable while out_valid
//   err        - sticky protocol-error flag
//
// Optional feature macro: MK_SYNC_HS_RX_ERR_EN
//   defined   - err latches when the request drops while a word is pending
//   undefined - err is tied low, no detection logic
//
// data_async is deliberately not synchronised: the protocol holds it stable
// across the capture point, so it is a false-path / max-delay crossing.
// ---------------------------------------------------------------------------
module mk_sync_hs_rx
  import mk_sync_hs_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SYNC_STAGE = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_async,
  input  logic [DATA_WIDTH-1:0] data_async,
  output logic                  ack,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  err
);

  logic                  req_s;
  hs_state_e             state_q;
  hs_state_e             state_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic [DATA_WIDTH-1:0] data_d;

  mk_sync_l2l #(
    .SYNC_STAGE  (SYNC_STAGE),
    .RESET_VALUE (1'b0)
  ) u_req_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (req_async),
    .q      (req_s)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        // Only capture point for data_async.
        if (req_s) begin
          data_d  = data_async;
          state_d = ST_VALID;
        end
      end
      ST_VALID: begin
        if (out_ready) begin
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        // Holding ack until the request falls completes the 4-phase cycle
        // and guarantees IDLE never sees a stale high request.
        if (!req_s) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // Outputs decode directly from flops, so they are glitch-free registers.
  assign ack       = (state_q == ST_ACK);
  assign out_valid = (state_q == ST_VALID);
  assign out_data  = data_q;

`ifdef MK_SYNC_HS_RX_ERR_EN
  logic err_q;
  logic err_d;

  always_comb begin
    err_d = err_q | ((state_q == ST_VALID) && !req_s);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;

  always @(posedge clk) begin
    if (resetn) begin
      assert (!((state_q == ST_VALID) && !req_s))
        else $warning("mk_sync_hs_rx: request dropped while word pending");
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mk_sync_hs_rx.sv
// ---------------------------------------------------------------------------
// tb_mk_sync_hs_rx
// Self-checking bench for mk_sync_hs_rx (DATA_WIDTH=32, SYNC_STAGE=2):
// cycle table for a basic transfer, hand sequences for backpressure, late
// data change, reset mid-transfer and protocol error, then source/consumer
// processes with a transaction-level queue model for sequential and random
// transfers.
// ---------------------------------------------------------------------------
module tb_mk_sync_hs_rx;

  localparam int DW   = 32;
  localparam int SYNC = 2;

`ifdef MK_SYNC_HS_RX_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          req_async = 1'b0;
  logic [DW-1:0] data_async = '0;
  logic          out_ready = 1'b0;
  logic          ack;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mk_sync_hs_rx #(
    .DATA_WIDTH (DW),
    .SYNC_STAGE (SYNC)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_async  (req_async),
    .data_async (data_async),
    .ack        (ack),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .err        (err)
  );

  typedef struct {
    logic          req;
    logic [DW-1:0] data;
    logic          ready;
    logic          exp_valid;
    logic          exp_ack;
    logic [DW-1:0] exp_data;
  } vec_t;

  vec_t tbl [8];

  logic [DW-1:0] exp_q [$];
  int            accepted;
  bit            src_done;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_valid(input logic v, input string nm);
    int k = 0;
    while (out_valid !== v && k < 100) begin
      tick();
      k++;
    end
    chk(nm, out_valid, v);
  endtask

  task automatic wait_ack(input logic v, input string nm);
    int k = 0;
    while (ack !== v && k < 100) begin
      tick();
      k++;
    end
    chk(nm, ack, v);
  endtask

  task automatic do_reset();
    resetn     = 1'b0;
    req_async  = 1'b0;
    out_ready  = 1'b0;
    data_async = '0;
    repeat (2) tick();
    chk("reset_valid", out_valid, 1'b0);
    chk("reset_ack", ack, 1'b0);
    chk("reset_data", out_data, '0);
    chk("reset_err", err, 1'b0);
    resetn = 1'b1;
    tick();
  endtask

  // Source-domain agent: one full 4-phase cycle per word.
  task automatic src_transfers(input int n, input bit seq, output int acks);
    acks = 0;
    for (int i = 0; i < n; i++) begin
      logic [DW-1:0] w;
      int k;
      w = seq ? DW'(i) : DW'($urandom);
      exp_q.push_back(w);
      data_async = w;
      req_async  = 1'b1;
      k = 0;
      while (ack !== 1'b1 && k < 300) begin tick(); k++; end
      chk("src_ack_rise", ack, 1'b1);
      if (ack !== 1'b1) break;
      data_async = $urandom;
      repeat ($urandom_range(0, 2)) tick();
      req_async = 1'b0;
      k = 0;
      while (ack !== 1'b0 && k < 300) begin tick(); k++; end
      chk("src_ack_fall", ack, 1'b0);
      if (ack !== 1'b0) break;
      acks++;
      repeat ($urandom_range(0, 3)) tick();
    end
  endtask

  // Local consumer with random ready; compares accepted words to the queue.
  task automatic consume(input int max_cycles);
    logic [DW-1:0] prev;
    bit            prev_v;
    bit            pend_ack;
    int            c;
    prev     = '0;
    prev_v   = 1'b0;
    pend_ack = 1'b0;
    c        = 0;
    while (!src_done && c < max_cycles) begin
      @(posedge clk);
      #1 out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (pend_ack) begin
        chk("ack_after_accept", ack, 1'b1);
        chk("valid_low_after_accept", out_valid, 1'b0);
        pend_ack = 1'b0;
      end
      if (out_valid === 1'b1) begin
        if (prev_v) chk("data_stable", out_data, prev);
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            chk("word_expected", DW'(exp_q.size() > 0), DW'(1));
          end else begin
            chk("word_order", out_data, exp_q.pop_front());
            accepted++;
          end
          pend_ack = 1'b1;
          prev_v   = 1'b0;
        end else begin
          prev   = out_data;
          prev_v = 1'b1;
        end
      end else begin
        prev_v = 1'b0;
      end
      c++;
    end
    out_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    logic [DW-1:0] b;

    b = 32'hDEADBEEF;
    tbl[0] = '{1'b1, b,  1'b1, 1'b0, 1'b0, '0};
    tbl[1] = '{1'b1, b,  1'b1, 1'b0, 1'b0, '0};
    tbl[2] = '{1'b1, b,  1'b1, 1'b1, 1'b0, b};
    tbl[3] = '{1'b1, b,  1'b1, 1'b0, 1'b1, b};
    tbl[4] = '{1'b0, b,  1'b1, 1'b0, 1'b1, b};
    tbl[5] = '{1'b0, b,  1'b1, 1'b0, 1'b1, b};
    tbl[6] = '{1'b0, '0, 1'b1, 1'b0, 1'b0, b};
    tbl[7] = '{1'b0, '0, 1'b1, 1'b0, 1'b0, b};

    do_reset();

    // Basic transfer, one row per clock edge.
    for (int i = 0; i < 8; i++) begin
      req_async  = tbl[i].req;
      data_async = tbl[i].data;
      out_ready  = tbl[i].ready;
      tick();
      chk($sformatf("basic_valid[%0d]", i), out_valid, tbl[i].exp_valid);
      chk($sformatf("basic_ack[%0d]", i), ack, tbl[i].exp_ack);
      chk($sformatf("basic_data[%0d]", i), out_data, tbl[i].exp_data);
    end

    // Backpressure.
    out_ready  = 1'b0;
    data_async = 32'h12345678;
    req_async  = 1'b1;
    wait_valid(1'b1, "bp_valid_rise");
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid_hold", out_valid, 1'b1);
      chk("bp_data_hold", out_data, 32'h12345678);
      chk("bp_ack_low", ack, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_ack_rise", ack, 1'b1);
    chk("bp_valid_fall", out_valid, 1'b0);
    req_async = 1'b0;
    wait_ack(1'b0, "bp_ack_fall");

    // Data change after capture.
    out_ready  = 1'b0;
    data_async = 32'hA5A5A5A5;
    req_async  = 1'b1;
    wait_valid(1'b1, "dchg_valid_rise");
    tick();
    data_async = 32'hFFFFFFFF;
    repeat (3) tick();
    chk("dchg_data_hold", out_data, 32'hA5A5A5A5);
    out_ready = 1'b1;
    tick();
    chk("dchg_ack_rise", ack, 1'b1);
    chk("dchg_data_after_accept", out_data, 32'hA5A5A5A5);
    req_async = 1'b0;
    wait_ack(1'b0, "dchg_ack_fall");

    // Reset mid-VALID with request still high.
    out_ready  = 1'b0;
    data_async = 32'hCAFEF00D;
    req_async  = 1'b1;
    wait_valid(1'b1, "rst_valid_rise");
    #2 resetn = 1'b0;
    #1;
    chk("rst_async_valid", out_valid, 1'b0);
    chk("rst_async_ack", ack, 1'b0);
    chk("rst_async_data", out_data, '0);
    @(posedge clk);
    #1 resetn = 1'b1;
    for (int e = 1; e <= SYNC + 1; e++) begin
      tick();
      chk($sformatf("rst_relatch_valid[%0d]", e), out_valid, (e == SYNC + 1) ? 1'b1 : 1'b0);
    end
    chk("rst_relatch_data", out_data, 32'hCAFEF00D);
    out_ready = 1'b1;
    tick();
    chk("rst_relatch_ack", ack, 1'b1);
    req_async = 1'b0;
    wait_ack(1'b0, "rst_relatch_ack_fall");

    // Request dropped during VALID.
    out_ready  = 1'b0;
    data_async = 32'h0BADC0DE;
    req_async  = 1'b1;
    wait_valid(1'b1, "err_valid_rise");
    req_async = 1'b0;
    repeat (SYNC + 1) tick();
    chk("err_set", err, ERR_EXP);
    chk("err_word_still_valid", out_valid, 1'b1);
    chk("err_word_data", out_data, 32'h0BADC0DE);
    out_ready = 1'b1;
    tick();
    chk("err_ack_rise", ack, 1'b1);
    wait_ack(1'b0, "err_ack_fall");
    tick();
    chk("err_sticky", err, ERR_EXP);

    // Back-to-back sequential words 0..7.
    do_reset();
    exp_q.delete();
    accepted = 0;
    src_done = 1'b0;
    fork
      begin
        src_transfers(8, 1'b1, acks);
        src_done = 1'b1;
      end
      consume(20000);
    join
    chk("b2b_ack_cycles", acks, 8);
    chk("b2b_accepted", accepted, 8);
    chk("b2b_queue_empty", exp_q.size(), 0);

    // Random words.
    exp_q.delete();
    accepted = 0;
    src_done = 1'b0;
    fork
      begin
        src_transfers(20, 1'b0, acks);
        src_done = 1'b1;
      end
      consume(20000);
    join
    chk("rand_ack_cycles", acks, 20);
    chk("rand_accepted", accepted, 20);
    chk("rand_queue_empty", exp_q.size(), 0);
    chk("rand_err_low", err, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
